// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter sitting beside dmem on the writeback store path.
//
// Register map (byte addresses, ALUResultW[1:0] ignored):
//   BASE_ADDR + 0  TXDATA  write-only; a store pushes WriteData[7:0] into the byte FIFO.
//   BASE_ADDR + 4  STATUS  read: {count[15:8], parity_en, overflow, busy, empty, full};
//                          write with WriteData[3]=1 clears the sticky overflow flag.
//
// Bytes leave on tx as 8N1 frames, LSB first, each bit held CLKS_PER_BIT cycles.
// Frames queued in the FIFO go out back-to-back with no idle gap between them.
//
// Optional feature, selected with `define MMIO_UART_TX_PARITY_EN:
//   adds an even-parity bit between the data bits and the stop bit (8E1) and reports
//   STATUS[4]=1. Without the macro the frame is plain 8N1 and STATUS[4]=0.

module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteW,
    input  logic [31:0] ALUResultW,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        sel,
    output logic        tx
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

    localparam logic [PtrW:0]    PtrOne     = (PtrW + 1)'(1);
    localparam logic [PtrW:0]    DepthVal   = (PtrW + 1)'(FIFO_DEPTH);
    localparam logic [BaudW-1:0] BaudReload = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BaudW-1:0] BaudOne    = BaudW'(1);

`ifdef MMIO_UART_TX_PARITY_EN
    localparam logic ParityEn = 1'b1;
`else
    localparam logic ParityEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef MMIO_UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } stateT;

    // Address decode and access qualification
    logic txDataHit;
    logic statusHit;
    logic txDataWr;
    logic statusWr;
    logic push;
    logic drop;
    logic clearOvf;

    // FIFO storage and pointers (one extra wrap bit distinguishes full from empty)
    logic [7:0]  fifoMem [FIFO_DEPTH];
    logic [PtrW:0] wrPtrQ, wrPtrD;
    logic [PtrW:0] rdPtrQ, rdPtrD;
    logic [PtrW:0] fifoCount;
    logic        fifoFull;
    logic        fifoEmpty;
    logic [7:0]  headByte;
    logic        pop;

    // Sticky overflow flag
    logic ovfQ, ovfD;

    // Serialiser state
    stateT            stateQ, stateD;
    logic [BaudW-1:0] baudQ, baudD;
    logic [7:0]       shiftQ, shiftD;
    logic [2:0]       bitIdxQ, bitIdxD;
    logic             txQ, txD;
    logic             baudExpired;
    logic             busy;

`ifdef MMIO_UART_TX_PARITY_EN
    logic parityQ, parityD;
`endif

    // Store data above the byte lane (bit 3 excepted) and the byte offset carry no meaning here.
    logic unusedBits;
    assign unusedBits = ^{ALUResultW[1:0], WriteData[31:8]};

    assign sel       = (ALUResultW[31:3] == BASE_ADDR[31:3]);
    assign txDataHit = sel && !ALUResultW[2];
    assign statusHit = sel && ALUResultW[2];
    assign txDataWr  = txDataHit && MemWriteW;
    assign statusWr  = statusHit && MemWriteW;

    assign fifoCount = wrPtrQ - rdPtrQ;
    assign fifoFull  = (fifoCount == DepthVal);
    assign fifoEmpty = (wrPtrQ == rdPtrQ);
    assign headByte  = fifoMem[rdPtrQ[PtrW-1:0]];

    // Fullness is judged on pre-edge state, so a pop on the same edge never makes room.
    assign push     = txDataWr && !fifoFull;
    assign drop     = txDataWr && fifoFull;
    assign clearOvf = statusWr && WriteData[3];

    assign baudExpired = (baudQ == '0);
    assign busy        = (stateQ != StIdle) || !fifoEmpty;
    assign tx          = txQ;

    // FIFO payload storage; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtrQ[PtrW-1:0]] <= WriteData[7:0];
        end
    end

    // FIFO pointer and overflow next-state
    always_comb begin
        wrPtrD = wrPtrQ;
        rdPtrD = rdPtrQ;
        ovfD   = ovfQ;
        if (push) begin
            wrPtrD = wrPtrQ + PtrOne;
        end
        if (pop) begin
            rdPtrD = rdPtrQ + PtrOne;
        end
        // A drop on the same edge as a clear leaves the flag set.
        if (clearOvf) begin
            ovfD = 1'b0;
        end
        if (drop) begin
            ovfD = 1'b1;
        end
    end

    // Serialiser next-state: frame sequencing, baud countdown and tx level
    always_comb begin
        stateD  = stateQ;
        baudD   = baudQ;
        shiftD  = shiftQ;
        bitIdxD = bitIdxQ;
        txD     = txQ;
        pop     = 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
        parityD = parityQ;
`endif

        case (stateQ)
            StIdle: begin
                txD = 1'b1;
                if (!fifoEmpty) begin
                    pop = 1'b1;
                end
            end

            StStart: begin
                if (baudExpired) begin
                    // The shift register always presents the next bit to send at [0].
                    txD     = shiftQ[0];
                    shiftD  = {1'b0, shiftQ[7:1]};
                    bitIdxD = 3'd0;
                    baudD   = BaudReload;
                    stateD  = StData;
                end else begin
                    baudD = baudQ - BaudOne;
                end
            end

            StData: begin
                if (baudExpired) begin
                    baudD = BaudReload;
                    if (bitIdxQ == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                        txD    = parityQ;
                        stateD = StParity;
`else
                        txD    = 1'b1;
                        stateD = StStop;
`endif
                    end else begin
                        txD     = shiftQ[0];
                        shiftD  = {1'b0, shiftQ[7:1]};
                        bitIdxD = bitIdxQ + 3'd1;
                    end
                end else begin
                    baudD = baudQ - BaudOne;
                end
            end

`ifdef MMIO_UART_TX_PARITY_EN
            StParity: begin
                if (baudExpired) begin
                    txD    = 1'b1;
                    baudD  = BaudReload;
                    stateD = StStop;
                end else begin
                    baudD = baudQ - BaudOne;
                end
            end
`endif

            StStop: begin
                if (baudExpired) begin
                    if (!fifoEmpty) begin
                        pop = 1'b1;
                    end else begin
                        txD    = 1'b1;
                        stateD = StIdle;
                    end
                end else begin
                    baudD = baudQ - BaudOne;
                end
            end

            default: begin
                txD    = 1'b1;
                stateD = StIdle;
            end
        endcase

        // Loading a new frame is identical from IDLE and from the end of a stop bit.
        if (pop) begin
            shiftD = headByte;
            txD    = 1'b0;
            baudD  = BaudReload;
            stateD = StStart;
`ifdef MMIO_UART_TX_PARITY_EN
            parityD = ^headByte;
`endif
        end
    end

    // State registers with synchronous reset; reset aborts any frame and empties the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtrQ  <= '0;
            rdPtrQ  <= '0;
            ovfQ    <= 1'b0;
            stateQ  <= StIdle;
            baudQ   <= '0;
            shiftQ  <= '0;
            bitIdxQ <= '0;
            txQ     <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
            parityQ <= 1'b0;
`endif
        end else begin
            wrPtrQ  <= wrPtrD;
            rdPtrQ  <= rdPtrD;
            ovfQ    <= ovfD;
            stateQ  <= stateD;
            baudQ   <= baudD;
            shiftQ  <= shiftD;
            bitIdxQ <= bitIdxD;
            txQ     <= txD;
`ifdef MMIO_UART_TX_PARITY_EN
            parityQ <= parityD;
`endif
        end
    end

    // Load path: STATUS word when STATUS is addressed, zero otherwise (TXDATA is write-only).
    always_comb begin
        ReadData = '0;
        if (statusHit) begin
            ReadData[0]    = fifoFull;
            ReadData[1]    = fifoEmpty;
            ReadData[2]    = busy;
            ReadData[3]    = ovfQ;
            ReadData[4]    = ParityEn;
            ReadData[15:8] = 8'(fifoCount);
        end
    end

endmodule
